kbd_scanner: RTL and testbench
==============================

# kbd_scanner

Serial keyboard front end for the TinyFPGA BX hera system. Drives the keyboard shift-register chain (latch and clock out, data in) and keeps a debounced key-state bitmap. Emits press/release events through a small FIFO that the memory manager pops when the CPU reads the keyboard I/O address. Sits between the keyboard pins and the memory manager; runs on the 16 MHz board clock.

## Interface
Parameters:
- `NUM_KEYS`, default 64: number of keys in the chain. Range 2..128.
- `CLK_DIV`, default 16: `clk` cycles per half period of `kbd_clk`, and the width of the latch pulse. Minimum 4.
- `FIFO_DEPTH`, default 8: event FIFO entries. Must be a power of two.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `kbd_latch`, out, 1: parallel-load strobe to the chain. High means load.
- `kbd_clk`, out, 1: shift clock to the chain. The chain shifts on the rising edge.
- `kbd_data`, in, 1: serial data from the chain. 1 means pressed. Asynchronous to `clk`.
- `key_state`, out, `NUM_KEYS`: debounced bitmap, bit i is key i.
- `evt_valid`, out, 1: FIFO not empty.
- `evt_data`, out, 8: FIFO head. Bit 7 is 1 for press and 0 for release; bits 6:0 are the key index.
- `evt_ready`, in, 1: pop request. The pop occurs when `evt_valid && evt_ready`.
- `overflow`, out, 1: sticky flag, set when an event is dropped.
- `ovf_clear`, in, 1: clears `overflow`.
- `scan_done`, out, 1: one-cycle pulse when a scan commits.

## Operation
- `kbd_data` passes through a 2-flop synchroniser before any use.
- The FSM runs LOAD, SHIFT_LO, SHIFT_HI, COMPARE, DONE, then returns to LOAD. It runs continuously.
- LOAD: `kbd_latch`=1 and `kbd_clk`=0 for `CLK_DIV` cycles. Bit index resets to 0.
- SHIFT_LO: `kbd_latch`=0 and `kbd_clk`=0 for `CLK_DIV` cycles. On the last cycle, the synced data is stored into `raw[bit]`.
- SHIFT_HI: `kbd_clk`=1 for `CLK_DIV` cycles. Afterwards, if `bit == NUM_KEYS-1` go to COMPARE; otherwise increment `bit` and go to SHIFT_LO.
- Debounce: `cand = raw & prev_raw` for press detection, and `~raw & ~prev_raw` for release detection. A key changes state only when two consecutive scans agree. `prev_raw` is updated to `raw` in DONE.
- COMPARE takes one cycle per key, index k = 0..`NUM_KEYS-1`:
  - If `key_state[k]`=0 and both scans read 1: push {1,k} and set the key.
  - If `key_state[k]`=1 and both scans read 0: push {0,k} and clear the key.
  - Otherwise no push.
- DONE: takes one cycle, pulses `scan_done`, updates `prev_raw`, then goes to LOAD.
- FIFO full on push:
  - The event is dropped and `overflow` is set.
  - `key_state` is still updated.
  - If a pop occurs in the same cycle as the push, the push is accepted.
- Pop on empty: ignored.
- `ovf_clear` in the same cycle as a drop: the set wins.
- Reset, including mid-scan, returns every output to its reset value: `kbd_latch`=0, `kbd_clk`=0, `key_state`=0, `evt_valid`=0, `evt_data`=0, `overflow`=0, `scan_done`=0. It also clears `raw`, `prev_raw`, the FIFO and the synchroniser. The FSM enters LOAD on the first cycle after `reset` deasserts.

## Timing
- All outputs are registered.
- Scan period is `CLK_DIV*(1+2*NUM_KEYS) + NUM_KEYS + 1` cycles. Defaults give 2129 cycles, about 133 µs.
- Sampling point is 2+ cycles after the falling edge, inside a `CLK_DIV` window, so the data is stable.
- A key change appears in `key_state` and on `evt_valid` at COMPARE of the second agreeing scan.
- The push for key k is visible in `evt_valid` one cycle after its COMPARE slot.
- FIFO pop: `evt_data` shows the next entry in the cycle after the pop.
- `scan_done` is high exactly 1 cycle per scan.

## Structure
- Package `kbd_pkg` holds:
  - FSM state encoding (LOAD, SHIFT_LO, SHIFT_HI, COMPARE, DONE);
  - `EVT_W`=8;
  - `EVT_PRESS_BIT`=7;
  - the index field width.
- Sub-module `kbd_event_fifo` is a synchronous FIFO parameterised on `FIFO_DEPTH` and `EVT_W`. It has push/pop, full/empty, and simultaneous push+pop support.
- The top level holds the FSM, divider counter, bit counter, synchroniser, raw/prev_raw/state registers and the overflow flag.

## Test plan
- Reset sequencing: hold `reset` 5 cycles. Check all outputs are 0. After release, `kbd_latch` rises on the next cycle and stays high 16 cycles. The first `scan_done` arrives 2129 cycles after the LOAD start.
- Single press: key 5 reads 1 for two scans. Expect `evt_data`=0x85 and `key_state[5]`=1 after the 2nd scan, with no event after the 1st.
- Release and glitch: key 5 pressed then released for 2 scans gives `evt_data`=0x05. Key 9 high for only 1 scan gives no event and `key_state[9]` stays 0.
- Overflow: press keys 0..9 together with `evt_ready`=0 and `FIFO_DEPTH`=8. Expect 8 events 0x80..0x87, `overflow`=1, and `key_state[9:0]`=0x3FF. `ovf_clear` then clears the flag.
- Concurrent push and pop: with the FIFO full and `evt_ready`=1 during COMPARE, no event is lost and `overflow` stays 0.
- Mid-scan reset: assert `reset` during SHIFT_HI of bit 30. Outputs return to 0, the FIFO empties, and the next scan starts cleanly with no spurious events.

Source files
------------

// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared constants, FSM encoding and event packing for the
//               serial keyboard scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam int EVT_W         = 8;
    localparam int EVT_PRESS_BIT = 7;
    localparam int IDX_W         = 7;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_LOAD     = 3'd0;
    localparam logic [ST_W-1:0] ST_SHIFT_LO = 3'd1;
    localparam logic [ST_W-1:0] ST_SHIFT_HI = 3'd2;
    localparam logic [ST_W-1:0] ST_COMPARE  = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE     = 3'd4;

    function automatic logic [EVT_W-1:0] make_evt(input logic press,
                                                  input logic [IDX_W-1:0] idx);
        logic [EVT_W-1:0] evt;
        evt                = '0;
        evt[IDX_W-1:0]     = idx;
        evt[EVT_PRESS_BIT] = press;
        return evt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kbd_event_fifo
// Description : Show-ahead synchronous FIFO with registered head and valid;
//               a push into a full FIFO is accepted when a pop happens too.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_event_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int EVT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [EVT_W-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [EVT_W-1:0] o_data,
    output logic             o_full,
    output logic             o_drop
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [EVT_W-1:0] r_head;
    logic             r_valid;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [c_AW:0]    w_wr_next;
    logic [c_AW:0]    w_rd_next;
    logic [EVT_W-1:0] w_head_next;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                       (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_pop     = i_pop && !w_empty;
    assign w_push    = i_push && (!w_full || w_pop);
    assign w_wr_next = r_wr_ptr + {{c_AW{1'b0}}, w_push};
    assign w_rd_next = r_rd_ptr + {{c_AW{1'b0}}, w_pop};

    // The new head may be the word being written this very cycle.
    always_comb begin
        w_head_next = r_mem[w_rd_next[c_AW-1:0]];
        if (w_push && (r_wr_ptr[c_AW-1:0] == w_rd_next[c_AW-1:0]))
            w_head_next = i_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push)
                r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_head   <= w_head_next;
            r_valid  <= (w_wr_next != w_rd_next);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_head;
    assign o_full  = w_full;
    assign o_drop  = i_push && !w_push;

endmodule
`default_nettype wire

// File: rtl/kbd_scanner.sv
`default_nettype none
// ============================================================================
// Module      : kbd_scanner
// Description : Scans the keyboard shift-register chain, debounces over two
//               scans and queues press/release events.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_scanner
    import kbd_pkg::*;
#(
    parameter int NUM_KEYS   = 64,
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                kbd_latch,
    output logic                kbd_clk,
    input  logic                kbd_data,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    output logic [EVT_W-1:0]    evt_data,
    input  logic                evt_ready,
    output logic                overflow,
    input  logic                ovf_clear,
    output logic                scan_done
);

    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_SEL_W = $clog2(NUM_KEYS);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_SEL_W-1:0] c_KEY_LAST = c_SEL_W'(NUM_KEYS - 1);

    logic                r_sync_meta;
    logic                r_sync;
    logic [ST_W-1:0]     r_state;
    logic [c_DIV_W-1:0]  r_cnt;
    logic [c_SEL_W-1:0]  r_bit;
    logic [NUM_KEYS-1:0] r_raw;
    logic [NUM_KEYS-1:0] r_prev_raw;

    logic                w_div_last;
    logic                w_press;
    logic                w_release;
    logic                w_push;
    logic [EVT_W-1:0]    w_evt;
    logic                w_drop;
    logic                w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= kbd_data;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_div_last = (r_cnt == c_DIV_LAST);

    // Debounce: a key flips only when this scan and the previous one agree.
    assign w_press   = (r_state == ST_COMPARE) && !key_state[r_bit] &&
                       r_raw[r_bit] && r_prev_raw[r_bit];
    assign w_release = (r_state == ST_COMPARE) && key_state[r_bit] &&
                       !r_raw[r_bit] && !r_prev_raw[r_bit];
    assign w_push    = w_press || w_release;
    assign w_evt     = make_evt(w_press, IDX_W'(r_bit));

    // Pin outputs are decoded from the state and registered, so every
    // phase appears one cycle after the FSM enters it, with lengths intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_LOAD;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_raw      <= '0;
            r_prev_raw <= '0;
            key_state  <= '0;
            kbd_latch  <= 1'b0;
            kbd_clk    <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            kbd_latch <= (r_state == ST_LOAD);
            kbd_clk   <= (r_state == ST_SHIFT_HI);
            scan_done <= (r_state == ST_DONE);
            case (r_state)
                ST_LOAD: begin
                    if (w_div_last) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= ST_SHIFT_LO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_div_last) begin
                        r_raw[r_bit] <= r_sync;
                        r_cnt        <= '0;
                        r_state      <= ST_SHIFT_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_div_last) begin
                        r_cnt <= '0;
                        if (r_bit == c_KEY_LAST) begin
                            r_bit   <= '0;
                            r_state <= ST_COMPARE;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_state <= ST_SHIFT_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (w_press)
                        key_state[r_bit] <= 1'b1;
                    else if (w_release)
                        key_state[r_bit] <= 1'b0;
                    if (r_bit == c_KEY_LAST) begin
                        r_bit   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_prev_raw <= r_raw;
                    r_state    <= ST_LOAD;
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    kbd_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .EVT_W      (EVT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_evt),
        .i_pop       (evt_ready),
        .o_valid     (evt_valid),
        .o_data      (evt_data),
        .o_full      (w_full),
        .o_drop      (w_drop)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (w_drop)
            overflow <= 1'b1;
        else if (ovf_clear)
            overflow <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_kbd_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_scanner
// Description : Self-checking bench for kbd_scanner with a keyboard chain
//               model, vector table, corner sequences and a random model run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_scanner;

    localparam int c_NUM_KEYS   = 64;
    localparam int c_CLK_DIV    = 16;
    localparam int c_FIFO_DEPTH = 8;
    localparam int c_SCAN_CYC   = c_CLK_DIV * (1 + 2 * c_NUM_KEYS) + c_NUM_KEYS + 1;
    localparam int c_CMP_OFS    = c_CLK_DIV * (1 + 2 * c_NUM_KEYS);

    logic        clk = 1'b0;
    logic        reset;
    logic        kbd_latch;
    logic        kbd_clk;
    logic        kbd_data;
    logic [63:0] key_state;
    logic        evt_valid;
    logic [7:0]  evt_data;
    logic        evt_ready;
    logic        overflow;
    logic        ovf_clear;
    logic        scan_done;

    int errors = 0;
    int checks = 0;

    kbd_scanner #(
        .NUM_KEYS   (c_NUM_KEYS),
        .CLK_DIV    (c_CLK_DIV),
        .FIFO_DEPTH (c_FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .kbd_latch (kbd_latch),
        .kbd_clk   (kbd_clk),
        .kbd_data  (kbd_data),
        .key_state (key_state),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    // Keyboard chain: parallel load while latched, shift on rising kbd_clk.
    logic [63:0] keys_now  = '0;
    logic [63:0] chain     = '0;
    logic [6:0]  chain_idx = '0;
    logic        kclk_q    = 1'b0;

    always @(posedge clk) begin
        kclk_q <= kbd_clk;
        if (kbd_latch) begin
            chain     <= keys_now;
            chain_idx <= '0;
        end else if (kbd_clk && !kclk_q) begin
            chain_idx <= chain_idx + 7'd1;
        end
    end

    always_comb kbd_data = chain_idx[6] ? 1'b0 : chain[chain_idx[5:0]];

    logic       mon_en = 1'b0;
    logic [7:0] got[$];

    always @(negedge clk)
        if (mon_en && evt_valid && evt_ready)
            got.push_back(evt_data);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_scan();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!scan_done && n < c_SCAN_CYC + 100);
        check("scan_done_arrival", 64'(scan_done), 64'd1);
    endtask

    task automatic pop();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic drain_expect(input string name, input logic [7:0] first, input int nevt);
        int j;
        j = 0;
        while (evt_valid && j < 16) begin
            check({name, "_data"}, 64'(evt_data), 64'(8'(first + j)));
            pop();
            j++;
        end
        check({name, "_count"}, 64'(j), 64'(nevt));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_latch"}, 64'(kbd_latch), 64'd0);
        check({name, "_kclk"},  64'(kbd_clk),   64'd0);
        check({name, "_state"}, key_state,      64'd0);
        check({name, "_valid"}, 64'(evt_valid), 64'd0);
        check({name, "_data"},  64'(evt_data),  64'd0);
        check({name, "_ovf"},   64'(overflow),  64'd0);
        check({name, "_done"},  64'(scan_done), 64'd0);
    endtask

    // Reference model: per-scan debounce rules and a bounded event queue.
    logic [63:0] m_state;
    logic [63:0] m_prev;
    logic [7:0]  m_q[$];
    logic        m_ovf;

    task automatic model_push(input logic [7:0] e);
        if (m_q.size() < c_FIFO_DEPTH) m_q.push_back(e);
        else m_ovf = 1'b1;
    endtask

    task automatic model_scan(input logic [63:0] p);
        for (int k = 0; k < c_NUM_KEYS; k++) begin
            if (!m_state[k] && p[k] && m_prev[k]) begin
                m_state[k] = 1'b1;
                model_push(8'h80 | 8'(k));
            end else if (m_state[k] && !p[k] && !m_prev[k]) begin
                m_state[k] = 1'b0;
                model_push(8'(k));
            end
        end
        m_prev = p;
    endtask

    typedef struct {
        logic [63:0] pat;
        logic [63:0] exp_state;
        int          exp_nevt;
        logic [7:0]  exp_first;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          cyc;
        int          n;
        logic [63:0] cur;
        logic [63:0] mask;
        logic [7:0]  exp_e;

        tbl[0] = '{64'h20,  64'h0,   0, 8'h85, 1'b0};
        tbl[1] = '{64'h20,  64'h20,  1, 8'h85, 1'b0};
        tbl[2] = '{64'h0,   64'h20,  0, 8'h05, 1'b0};
        tbl[3] = '{64'h0,   64'h0,   1, 8'h05, 1'b0};
        tbl[4] = '{64'h200, 64'h0,   0, 8'h89, 1'b0};
        tbl[5] = '{64'h0,   64'h0,   0, 8'h89, 1'b0};
        tbl[6] = '{64'h3FF, 64'h0,   0, 8'h80, 1'b0};
        tbl[7] = '{64'h3FF, 64'h3FF, 8, 8'h80, 1'b1};

        reset     = 1'b1;
        evt_ready = 1'b0;
        ovf_clear = 1'b0;
        keys_now  = tbl[0].pat;
        repeat (5) tick();
        check_reset_outputs("reset");
        reset = 1'b0;

        // cyc counts cycles from the first LOAD cycle
        tick();
        cyc = 1;
        check("latch_rise", 64'(kbd_latch), 64'd1);
        n = 1;
        while (n < 100) begin
            tick();
            cyc++;
            if (!kbd_latch) break;
            n++;
        end
        check("latch_width", 64'(n), 64'd16);
        while (!scan_done && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("first_scan_done_cycle", 64'(cyc), 64'(c_SCAN_CYC));

        for (int i = 0; i < 8; i++) begin
            if (i > 0) wait_scan();
            keys_now = (i < 7) ? tbl[i + 1].pat : tbl[i].pat;
            check($sformatf("vec%0d_key_state", i), key_state, tbl[i].exp_state);
            check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(tbl[i].exp_ovf));
            tick();
            check($sformatf("vec%0d_done_width", i), 64'(scan_done), 64'd0);
            drain_expect($sformatf("vec%0d_evt", i), tbl[i].exp_first, tbl[i].exp_nevt);
        end

        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("ovf_clear", 64'(overflow), 64'd0);

        // Fill the FIFO with presses 10..17, then pop during the release COMPARE.
        wait_scan();
        keys_now = 64'h3FFFF;
        wait_scan();
        wait_scan();
        keys_now = 64'h3FF;
        check("cc_prefill_valid", 64'(evt_valid), 64'd1);
        check("cc_prefill_state", key_state, 64'h3FFFF);
        wait_scan();
        mon_en = 1'b1;
        repeat (c_CMP_OFS) @(posedge clk);
        #1;
        evt_ready = 1'b1;
        wait_scan();
        repeat (20) tick();
        evt_ready = 1'b0;
        mon_en    = 1'b0;
        check("cc_count", 64'(got.size()), 64'd16);
        for (int j = 0; j < 16; j++) begin
            exp_e = (j < 8) ? 8'(8'h8A + j) : 8'(8'h0A + j - 8);
            if (j < got.size())
                check($sformatf("cc_evt%0d", j), 64'(got[j]), 64'(exp_e));
        end
        check("cc_overflow", 64'(overflow), 64'd0);
        check("cc_state", key_state, 64'h3FF);

        // Leave queued events and a set overflow, then reset in SHIFT_HI of bit 30.
        keys_now = 64'h0;
        wait_scan();
        wait_scan();
        wait_scan();
        check("pre_rst_ovf", 64'(overflow), 64'd1);
        check("pre_rst_valid", 64'(evt_valid), 64'd1);
        keys_now = 64'h8;
        repeat (1000) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        wait_scan();
        check("midrst_scan1_valid", 64'(evt_valid), 64'd0);
        check("midrst_scan1_state", key_state, 64'h0);
        wait_scan();
        check("midrst_scan2_state", key_state, 64'h8);
        drain_expect("midrst_evt", 8'h83, 1);

        // Random key activity against the reference model.
        reset = 1'b1;
        repeat (3) tick();
        m_state = '0;
        m_prev  = '0;
        m_q.delete();
        m_ovf   = 1'b0;
        cur = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
        keys_now = cur;
        reset = 1'b0;
        for (int s = 0; s < 10; s++) begin
            wait_scan();
            model_scan(cur);
            mask = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            if ($urandom_range(0, 2) == 0) mask = '0;
            cur      = cur ^ mask;
            keys_now = cur;
            check($sformatf("rnd%0d_state", s), key_state, m_state);
            check($sformatf("rnd%0d_ovf", s), 64'(overflow), 64'(m_ovf));
            while (m_q.size() > 0) begin
                exp_e = m_q.pop_front();
                check($sformatf("rnd%0d_valid", s), 64'(evt_valid), 64'd1);
                check($sformatf("rnd%0d_evt", s), 64'(evt_data), 64'(exp_e));
                pop();
            end
            check($sformatf("rnd%0d_empty", s), 64'(evt_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
